// File: rtl/pace_gearbox_oup_pkg.sv
// Shared types and helpers for the PACE output gearbox.
package pace_oup_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } gearbox_state_e;

  localparam int unsigned STATS_CNT_W = 32;
  // Widest strobe vector the helper can describe; callers size-cast the result down.
  localparam int unsigned STRB_MAX_W  = 1024;

  function automatic logic [STRB_MAX_W-1:0] lane_strb(
    input int unsigned n,
    input int unsigned pack_factor,
    input int unsigned lane_width
  );
    logic [STRB_MAX_W-1:0] strb;
    strb = '0;
    for (int unsigned i = 0; i < STRB_MAX_W; i++) begin
      if ((i < (n * lane_width) / 8) && (i < (pack_factor * lane_width) / 8)) begin
        strb[i] = 1'b1;
      end else begin
        strb[i] = 1'b0;
      end
    end
    return strb;
  endfunction

endpackage

// File: rtl/pace_gearbox_oup_if.sv
// Valid/ready stream carrying packed data words with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/pace_gearbox_lane_buf.sv
// Holds the lanes of a word that are still waiting for the closing beat.
module pace_gearbox_lane_buf #(
  parameter int unsigned NumLanes  = 3,
  parameter int unsigned LaneWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [NumLanes-1:0]           we_i,
  input  logic [LaneWidth-1:0]          wdata_i,
  output logic [NumLanes*LaneWidth-1:0] buf_o
);

  logic [NumLanes-1:0][LaneWidth-1:0] buf_q;

  // Per-lane write; clear wipes every lane.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      buf_q <= '0;
    end else begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        if (we_i[l]) begin
          buf_q[l] <= wdata_i;
        end
      end
    end
  end

  assign buf_o = buf_q;

endmodule

// File: rtl/pace_gearbox_oup.sv
// Packs PackFactor engine beats into one output word, with flush of partial words.
// Optional counters behind PACE_GEARBOX_OUP_STATS_EN.
module pace_gearbox_oup
  import pace_oup_pkg::*;
#(
  parameter  int unsigned NumRows      = 8,
  parameter  int unsigned InpDataWidth = 16,
  parameter  int unsigned PackFactor   = 4,
  localparam int unsigned LaneWidth    = NumRows * InpDataWidth,
  localparam int unsigned OupDataWidth = PackFactor * LaneWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic [NumRows*InpDataWidth-1:0] input_i,
  input  logic                          valid_i,
  output logic                          ready_o,
`ifdef PACE_GEARBOX_OUP_STATS_EN
  output logic [STATS_CNT_W-1:0]        words_full_o,
  output logic [STATS_CNT_W-1:0]        words_part_o,
`endif
  hwpe_stream_intf_stream.source        output_o
);

  localparam int unsigned CntW        = $clog2(PackFactor);
  localparam int unsigned NumBufLanes = PackFactor - 1;
  localparam int unsigned StrbW       = OupDataWidth / 8;

  gearbox_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumBufLanes*LaneWidth-1:0] buf_s;
  logic [NumBufLanes-1:0]           buf_we_s;
  logic [OupDataWidth-1:0]          drain_data_s;
  logic [OupDataWidth-1:0]          data_s;
  logic [StrbW-1:0]                 strb_s;
  logic                             ready_s;
  logic                             valid_s;
  logic                             store_s;
  logic                             full_hs_s;
  logic                             part_hs_s;
  logic                             last_lane_s;

  assign last_lane_s = (cnt_q == CntW'(PackFactor - 1));

  pace_gearbox_lane_buf #(
    .NumLanes  (NumBufLanes),
    .LaneWidth (LaneWidth)
  ) i_lane_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .we_i    (buf_we_s),
    .wdata_i (input_i),
    .buf_o   (buf_s)
  );

  // Partial word: lanes beyond the fill level are stale and must read as zero.
  always_comb begin
    drain_data_s = '0;
    for (int unsigned l = 0; l < NumBufLanes; l++) begin
      if (l < 32'(cnt_q)) begin
        drain_data_s[l*LaneWidth +: LaneWidth] = buf_s[l*LaneWidth +: LaneWidth];
      end else begin
        drain_data_s[l*LaneWidth +: LaneWidth] = '0;
      end
    end
  end

  // Next-state and handshake logic; the closing lane bypasses the buffer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_s   = 1'b0;
    valid_s   = 1'b0;
    store_s   = 1'b0;
    full_hs_s = 1'b0;
    part_hs_s = 1'b0;
    data_s    = {input_i, buf_s};
    strb_s    = '1;
    if (clear_i) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (!enable_i) begin
      state_d = state_q;
    end else begin
      case (state_q)
        FILL: begin
          if (last_lane_s) begin
            valid_s = valid_i;
            ready_s = output_o.ready;
            if (valid_i && output_o.ready) begin
              full_hs_s = 1'b1;
              cnt_d     = '0;
            end else if (flush_i) begin
              state_d = DRAIN;
            end else begin
              state_d = FILL;
            end
          end else begin
            ready_s = 1'b1;
            if (valid_i) begin
              store_s = 1'b1;
              cnt_d   = cnt_q + CntW'(1);
            end else begin
              cnt_d = cnt_q;
            end
            if (flush_i && (valid_i || (cnt_q != '0))) begin
              state_d = DRAIN;
            end else begin
              state_d = FILL;
            end
          end
        end
        DRAIN: begin
          valid_s = 1'b1;
          data_s  = drain_data_s;
          strb_s  = StrbW'(lane_strb(32'(cnt_q), PackFactor, LaneWidth));
          if (output_o.ready) begin
            part_hs_s = 1'b1;
            cnt_d     = '0;
            state_d   = FILL;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // One-hot lane write strobe from the current fill position.
  always_comb begin
    buf_we_s = '0;
    for (int unsigned l = 0; l < NumBufLanes; l++) begin
      if (store_s && (32'(cnt_q) == l)) begin
        buf_we_s[l] = 1'b1;
      end else begin
        buf_we_s[l] = 1'b0;
      end
    end
  end

  // FSM state and lane counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o         = ready_s;
  assign output_o.valid  = valid_s;
  assign output_o.data   = data_s;
  assign output_o.strb   = strb_s;

`ifdef PACE_GEARBOX_OUP_STATS_EN
  logic [STATS_CNT_W-1:0] words_full_q, words_part_q;

  // Saturating emission counters.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      words_full_q <= '0;
      words_part_q <= '0;
    end else begin
      if (full_hs_s && (words_full_q != '1)) begin
        words_full_q <= words_full_q + STATS_CNT_W'(1);
      end
      if (part_hs_s && (words_part_q != '1)) begin
        words_part_q <= words_part_q + STATS_CNT_W'(1);
      end
    end
  end

  assign words_full_o = words_full_q;
  assign words_part_o = words_part_q;
`else
  logic unused_hs_s;
  assign unused_hs_s = full_hs_s ^ part_hs_s;
`endif

endmodule

// File: tb/tb_pace_gearbox_oup.sv
// Self-checking bench for pace_gearbox_oup: vector table, corner sequences, random vs. queue model.
module tb_pace_gearbox_oup;

  localparam int unsigned NR  = 2;
  localparam int unsigned IDW = 16;
  localparam int unsigned PF  = 4;
  localparam int unsigned LW  = NR * IDW;
  localparam int unsigned OW  = PF * LW;
  localparam int unsigned SW  = OW / 8;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic clear_i = 1'b0;
  logic enable_i = 1'b1;
  logic flush_i = 1'b0;
  logic valid_i = 1'b0;
  logic [LW-1:0] input_i = '0;
  logic ready_o;

  int n_chk = 0;
  int n_fail = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(OW)) out_if ();

`ifdef PACE_GEARBOX_OUP_STATS_EN
  logic [31:0] words_full_o, words_part_o;
`endif

  pace_gearbox_oup #(
    .NumRows      (NR),
    .InpDataWidth (IDW),
    .PackFactor   (PF)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .enable_i (enable_i),
    .flush_i  (flush_i),
    .input_i  (input_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
`ifdef PACE_GEARBOX_OUP_STATS_EN
    .words_full_o (words_full_o),
    .words_part_o (words_part_o),
`endif
    .output_o (out_if)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored lanes plus a "partial word pending" flag.
  logic [LW-1:0] lanes[$];
  bit drain_m = 1'b0;
  int full_m = 0;
  int part_m = 0;

  typedef struct packed {
    logic          en;
    logic          fl;
    logic          vld;
    logic [LW-1:0] din;
    logic          ordy;
    logic          er;
    logic          ev;
    logic [OW-1:0] ed;
    logic [SW-1:0] es;
  } vec_t;

  function automatic vec_t mk(logic fl, logic vld, logic [LW-1:0] din, logic er, logic ev,
                              logic [OW-1:0] ed, logic [SW-1:0] es);
    vec_t v;
    v.en = 1'b1; v.fl = fl; v.vld = vld; v.din = din; v.ordy = 1'b1;
    v.er = er; v.ev = ev; v.ed = ed; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic en, input logic clr, input logic fl, input logic vld,
                       input logic [LW-1:0] din, input logic ordy,
                       output logic er, output logic ev, output logic [OW-1:0] ed,
                       output logic [SW-1:0] es);
    int n;
    er = 1'b0; ev = 1'b0; ed = '0; es = '1;
    n = lanes.size();
    for (int k = 0; k < n; k++) ed[k*LW +: LW] = lanes[k];
    if (clr) begin
      lanes.delete(); drain_m = 1'b0; full_m = 0; part_m = 0;
    end else if (!en) begin
      er = 1'b0;
    end else if (drain_m) begin
      ev = 1'b1;
      for (int i = 0; i < SW; i++) es[i] = (i < n * LW / 8);
      if (ordy) begin
        lanes.delete(); drain_m = 1'b0; part_m++;
      end
    end else if (n == PF - 1) begin
      er = ordy; ev = vld;
      ed[(PF-1)*LW +: LW] = din;
      if (vld && ordy) begin
        lanes.delete(); full_m++;
      end else if (fl) begin
        drain_m = 1'b1;
      end
    end else begin
      er = 1'b1;
      if (vld) lanes.push_back(din);
      if (fl && lanes.size() > 0) drain_m = 1'b1;
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic fl, input logic vld,
                      input logic [LW-1:0] din, input logic ordy, input string tag);
    logic er, ev;
    logic [OW-1:0] ed;
    logic [SW-1:0] es;
    @(negedge clk);
    enable_i = en; clear_i = clr; flush_i = fl; valid_i = vld; input_i = din;
    out_if.ready = ordy;
    #1;
    model(en, clr, fl, vld, din, ordy, er, ev, ed, es);
    chk({tag, " ready"}, OW'(ready_o), OW'(er));
    chk({tag, " valid"}, OW'(out_if.valid), OW'(ev));
    if (ev) begin
      chk({tag, " data"}, out_if.data, ed);
      chk({tag, " strb"}, OW'(out_if.strb), OW'(es));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; enable_i = 1'b1; clear_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    out_if.ready = 1'b1;
    @(negedge clk);
    #1;
    chk("reset ready", OW'(ready_o), OW'(1'b1));
    chk("reset valid", OW'(out_if.valid), OW'(1'b0));
    rst_i = 1'b0;
    lanes.delete(); drain_m = 1'b0; full_m = 0; part_m = 0;
  endtask

  vec_t tbl[15];

  initial begin
    logic [LW-1:0] d;
    tbl[0]  = mk(1'b0, 1'b1, 32'h0001_0000, 1'b1, 1'b0, '0, '0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h0003_0002, 1'b1, 1'b0, '0, '0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h0005_0004, 1'b1, 1'b0, '0, '0);
    tbl[3]  = mk(1'b0, 1'b1, 32'h0007_0006, 1'b1, 1'b1,
                 128'h0007_0006_0005_0004_0003_0002_0001_0000, 16'hFFFF);
    tbl[4]  = mk(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, '0, '0);
    tbl[5]  = mk(1'b0, 1'b1, 32'hBBBB_BBBB, 1'b1, 1'b0, '0, '0);
    tbl[6]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, '0, '0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1,
                 128'h0000_0000_0000_0000_BBBB_BBBB_AAAA_AAAA, 16'h00FF);
    tbl[8]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, '0, '0);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, '0, '0);
    tbl[10] = mk(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, '0, '0);
    tbl[11] = mk(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, '0, '0);
    tbl[12] = mk(1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, '0, '0);
    tbl[13] = mk(1'b1, 1'b1, 32'h4444_4444, 1'b1, 1'b1,
                 128'h4444_4444_3333_3333_2222_2222_1111_1111, 16'hFFFF);
    tbl[14] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, '0, '0);

    out_if.ready = 1'b1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      enable_i = tbl[i].en; clear_i = 1'b0; flush_i = tbl[i].fl; valid_i = tbl[i].vld;
      input_i = tbl[i].din; out_if.ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d ready", i), OW'(ready_o), OW'(tbl[i].er));
      chk($sformatf("vec%0d valid", i), OW'(out_if.valid), OW'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d data", i), out_if.data, tbl[i].ed);
        chk($sformatf("vec%0d strb", i), OW'(out_if.strb), OW'(tbl[i].es));
      end
    end

    // Output stall on the closing beat: word held steady, then emitted when ready rises.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'(2*i+1) << 16 | 32'(2*i), 1'b1, "stall fill");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0007_0006, 1'b0, "stall hold");
      chk("stall ready low", OW'(ready_o), OW'(1'b0));
      chk("stall data", out_if.data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0007_0006, 1'b1, "stall release");
    chk("stall emit", OW'(out_if.valid), OW'(1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "stall after");

    // Clear while a 3-lane partial word is pending.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, "clr fill");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, "clr flush");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "clr drain");
    chk("clr drain strb", OW'(out_if.strb), OW'(16'h0FFF));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "clr pulse");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h5000_0000 + 32'(i), 1'b1, "clr refill");
    chk("clr clean word", out_if.data, 128'h5000_0003_5000_0002_5000_0001_5000_0000);

    // Reset in the middle of a fill.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_0001, 1'b1, "rst fill");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_0002, 1'b1, "rst fill");
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h6000_0000 + 32'(i), 1'b1, "rst refill");
    chk("rst clean word", out_if.data, 128'h6000_0003_6000_0002_6000_0001_6000_0000);

`ifdef PACE_GEARBOX_OUP_STATS_EN
    do_reset();
    for (int w = 0; w < 12; w++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'(w), 1'b1, "stats full");
    for (int p = 0; p < 2; p++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h7700 + 32'(p), 1'b1, "stats part");
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, "stats flush");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "stats drain");
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "stats idle");
    chk("words_full", OW'(words_full_o), OW'(32'd3));
    chk("words_part", OW'(words_part_o), OW'(32'd2));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "stats clear");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "stats idle");
    chk("words_full cleared", OW'(words_full_o), OW'(32'd0));
    chk("words_part cleared", OW'(words_part_o), OW'(32'd0));
`endif

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      d = $urandom();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 7, $sformatf("rnd%0d", c));
    end
`ifdef PACE_GEARBOX_OUP_STATS_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "rnd idle");
    chk("rnd words_full", OW'(words_full_o), OW'(full_m));
    chk("rnd words_part", OW'(words_part_o), OW'(part_m));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
